// File: rtl/fetch_queue.sv
// Instruction prefetch queue: DEPTH-entry circular buffer of {instr, pc} between
// the instruction-memory read port and decode. A redirect flush discards all entries.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_mem_valid,
    input  logic [WIDTH-1:0]        i_mem_instr,
    input  logic [WIDTH-1:0]        i_mem_pc,
    output logic                    o_mem_ready,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_instr,
    output logic [WIDTH-1:0]        o_pc,
    input  logic                    i_ready,
    output logic                    o_advance,
    input  logic                    i_flush,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned        AW   = $clog2(DEPTH);
    localparam logic [AW:0]        FULL = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0]   NOP  = WIDTH'(32'h0000_0013);

    logic [WIDTH-1:0] r_instr [DEPTH];
    logic [WIDTH-1:0] r_pc    [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_push;
    logic             w_pop;

    always_comb begin
        o_mem_ready = (r_count != FULL);
        o_valid     = (r_count != '0);
        o_advance   = o_valid & i_ready;
        w_push      = i_mem_valid & o_mem_ready & ~i_flush;
        w_pop       = o_valid & i_ready & ~i_flush;
        o_count     = r_count;
        // Empty head reads as a NOP so the downstream history never latches stale data.
        o_instr     = NOP;
        o_pc        = '0;
        if (o_valid) begin
            o_instr = r_instr[r_rd_ptr];
            o_pc    = r_pc[r_rd_ptr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= i_mem_instr;
            r_pc[r_wr_ptr]    <= i_mem_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, WIDTH=32).
// Inputs are driven on the falling edge; outputs are checked 1 time unit later.
module tb_fetch_queue;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_mem_valid;
    logic [31:0] i_mem_instr;
    logic [31:0] i_mem_pc;
    logic        o_mem_ready;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        o_advance;
    logic        i_flush;
    logic [2:0]  o_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_queue #(
        .DEPTH (4),
        .WIDTH (32)
    ) u_dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_mem_valid (i_mem_valid),
        .i_mem_instr (i_mem_instr),
        .i_mem_pc    (i_mem_pc),
        .o_mem_ready (o_mem_ready),
        .o_valid     (o_valid),
        .o_instr     (o_instr),
        .o_pc        (o_pc),
        .i_ready     (i_ready),
        .o_advance   (o_advance),
        .i_flush     (i_flush),
        .o_count     (o_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        @(negedge i_clk);
        i_mem_valid = v;
        i_mem_pc    = pc;
        i_mem_instr = instr_of(pc);
        i_ready     = rdy;
        i_flush     = fl;
        #1;
    endtask

    initial begin
        int unsigned m_count;
        logic [31:0] push_pc;
        logic [31:0] pop_pc;
        int unsigned popped;
        logic        m_push;
        logic        m_pop;

        i_reset_n   = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_pc    = '0;
        i_mem_instr = '0;
        i_ready     = 1'b0;
        i_flush     = 1'b0;
        #2;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_ready", {31'b0, o_mem_ready}, 32'd1);
        chk("rst_count", {29'b0, o_count}, 32'd0);
        chk("rst_instr", o_instr, NOP);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_adv", {31'b0, o_advance}, 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Fill to full with decode stalled
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(4 * k), 1'b0, 1'b0);
            chk("fill_count", {29'b0, o_count}, 32'(k));
            chk("fill_mready", {31'b0, o_mem_ready}, 32'd1);
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        chk("full_count", {29'b0, o_count}, 32'd4);
        chk("full_mready", {31'b0, o_mem_ready}, 32'd0);
        chk("full_head_pc", o_pc, 32'h0);
        chk("full_head_instr", o_instr, instr_of(32'h0));
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        chk("hold_count", {29'b0, o_count}, 32'd4);
        // Pop while full: word 0x10 still refused this cycle
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        chk("fullpop_mready", {31'b0, o_mem_ready}, 32'd0);
        chk("fullpop_adv", {31'b0, o_advance}, 32'd1);
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        chk("after_pop_count", {29'b0, o_count}, 32'd3);
        chk("after_pop_mready", {31'b0, o_mem_ready}, 32'd1);
        chk("after_pop_pc", o_pc, 32'h4);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            chk("drain_pc", o_pc, 32'(4 + 4 * k));
            chk("drain_adv", {31'b0, o_advance}, 32'd1);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("drained_valid", {31'b0, o_valid}, 32'd0);
        chk("drained_instr", o_instr, NOP);

        // Ordering across pointer wrap with random pops
        m_count = 0;
        push_pc = 32'h100;
        pop_pc  = 32'h100;
        popped  = 0;
        for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
            drive(push_pc <= 32'h124, push_pc, 1'($urandom_range(0, 1)), 1'b0);
            chk("wrap_count", {29'b0, o_count}, 32'(m_count));
            chk("wrap_mready", {31'b0, o_mem_ready}, {31'b0, m_count != 4});
            m_push = i_mem_valid && (m_count != 4);
            m_pop  = (m_count != 0) && i_ready;
            if (o_advance) begin
                chk("wrap_pc", o_pc, pop_pc);
                chk("wrap_instr", o_instr, instr_of(pop_pc));
            end
            if (m_pop) begin
                pop_pc += 32'd4;
                popped++;
            end
            if (m_push) push_pc += 32'd4;
            m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
        end
        chk("wrap_all_popped", popped, 32'd10);

        // Sustained push+pop at occupancy 2
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        drive(1'b1, 32'h504, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'(32'h508 + 4 * k), 1'b1, 1'b0);
            chk("sim_count", {29'b0, o_count}, 32'd2);
            chk("sim_adv", {31'b0, o_advance}, 32'd1);
            chk("sim_mready", {31'b0, o_mem_ready}, 32'd1);
            chk("sim_pc", o_pc, 32'(32'h500 + 4 * k));
        end
        drive(1'b1, 32'h528, 1'b0, 1'b0);
        chk("sim_end_count", {29'b0, o_count}, 32'd2);

        // Flush at occupancy 3 with a word offered
        drive(1'b1, 32'h200, 1'b0, 1'b1);
        chk("pre_flush_count", {29'b0, o_count}, 32'd3);
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        chk("flush_count", {29'b0, o_count}, 32'd0);
        chk("flush_valid", {31'b0, o_valid}, 32'd0);
        chk("flush_instr", o_instr, NOP);
        chk("flush_pc", o_pc, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_flush_pc", o_pc, 32'h300);
        chk("post_flush_count", {29'b0, o_count}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("no_0x200_valid", {31'b0, o_valid}, 32'd0);

        // Full with pop while memory holds 0x40
        for (int k = 0; k < 4; k++) drive(1'b1, 32'(32'h30 + 4 * k), 1'b0, 1'b0);
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        chk("fp1_count", {29'b0, o_count}, 32'd4);
        chk("fp1_mready", {31'b0, o_mem_ready}, 32'd0);
        chk("fp1_pc", o_pc, 32'h30);
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        chk("fp2_count", {29'b0, o_count}, 32'd3);
        chk("fp2_mready", {31'b0, o_mem_ready}, 32'd1);
        chk("fp2_pc", o_pc, 32'h34);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            chk("fp_drain_count", {29'b0, o_count}, 32'(3 - k));
            chk("fp_drain_pc", o_pc, 32'(32'h38 + 4 * k));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fp_empty", {31'b0, o_valid}, 32'd0);

        // Asynchronous reset mid-stream at occupancy 3
        for (int k = 0; k < 3; k++) drive(1'b1, 32'(32'h600 + 4 * k), 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_count", {29'b0, o_count}, 32'd3);
        #1;
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("mid_rst_count", {29'b0, o_count}, 32'd0);
        chk("mid_rst_instr", o_instr, NOP);
        chk("mid_rst_pc", o_pc, 32'd0);
        chk("mid_rst_mready", {31'b0, o_mem_ready}, 32'd1);
        chk("mid_rst_adv", {31'b0, o_advance}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
